pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_unit_if.sv | 41 ++++
 rtl/pc_ras.sv | 80 ++++++++
 rtl/pc_unit.sv | 116 +++++++++++
 tb/tb_pc_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: opcode encodings,
// compare-flag bit positions and the return-address-stack index type.
package pc_pkg;

  // Opcodes with non-sequential behaviour; every other encoding is pc+1.
  localparam logic [3:0] OP_BEQ  = 4'b0101;
  localparam logic [3:0] OP_BNE  = 4'b0110;
  localparam logic [3:0] OP_BGE  = 4'b0111;
  localparam logic [3:0] OP_BLT  = 4'b1001;
  localparam logic [3:0] OP_JAL  = 4'b1011;
  localparam logic [3:0] OP_JALR = 4'b1100;
  localparam logic [3:0] OP_RET  = 4'b1101;

  // Bit positions inside the {eq,ne,ge,lt} compare vector.
  localparam int CMP_EQ = 3;
  localparam int CMP_NE = 2;
  localparam int CMP_GE = 1;
  localparam int CMP_LT = 0;

  // RAS pointer type. The pointer free-runs over its full width and the
  // low clog2(RAS_DEPTH) bits select the slot, so any power-of-two depth
  // up to 2**RAS_IDX_W wraps correctly.
  localparam int RAS_IDX_W = 8;
  typedef logic [RAS_IDX_W-1:0] ras_idx_t;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of all non-clock signals of pc_unit.
//
// Handshake: in_valid says a decoded instruction for the current pc is
// present. There is no ready; stall is the back-pressure. A step is taken
// on a rising edge only when in_valid=1, stall=0 and flush=0. flush
// overrides both and redirects the pc. link_we and redirect are single-cycle
// pulses produced on the edge that performed the step (or flush).
interface pc_unit_if #(
  parameter int XLEN      = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic            in_valid;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic [3:0]      opcode;
  logic [3:0]      compare;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] ra;
  logic            clear_flags;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] link;
  logic            link_we;
  logic            redirect;
  logic [CW-1:0]   ras_count;
  logic            ras_overflow;
  logic            ras_underflow;

  modport master (
    output in_valid, stall, flush, flush_pc, opcode, compare, imm, ra, clear_flags,
    input  pc, link, link_we, redirect, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  in_valid, stall, flush, flush_pc, opcode, compare, imm, ra, clear_flags,
    output pc, link, link_we, redirect, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack with circular storage. A push when full overwrites
// the oldest entry; a pop when empty is ignored. Both cases raise sticky
// flags that clear_flags_i resets unless a new error occurs the same cycle.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [XLEN-1:0]                push_data_i,
  input  logic                           clear_flags_i,
  output logic [XLEN-1:0]                top_o,
  output logic [$clog2(RAS_DEPTH):0]     count_o,
  output logic                           overflow_o,
  output logic                           underflow_o
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  ras_idx_t        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            full, empty;

  assign full  = (count_q == CW'(RAS_DEPTH));
  assign empty = (count_q == '0);

  // Top of stack is the slot just below the write pointer.
  assign top_o       = mem_q[AW'(wr_ptr_q - 1'b1)];
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

  // Pointer, occupancy and sticky-flag next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = clear_flags_i ? 1'b0 : ovf_q;
    unf_d    = clear_flags_i ? 1'b0 : unf_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + 1'b1;
    end else if (pop_i) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q - 1'b1;
        count_d  = count_q - 1'b1;
      end
    end
  end

  // Control state; reset discards the stack by zeroing the occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Entry storage; contents are meaningless when not counted, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[AW'(wr_ptr_q)] <= push_data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential/branch/jump/return next-pc selection,
// link register with one-cycle write strobe, redirect pulse and a
// return-address stack for call/return prediction.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_unit_if.slave  bus
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] link_q, link_d;
  logic            link_we_q, link_we_d;
  logic            redirect_q, redirect_d;

  logic            step;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] target_pc;
  logic            is_link;
  logic            is_ret;
  logic [XLEN-1:0] ras_top;
  logic [$clog2(RAS_DEPTH):0] ras_count;
  logic            ras_ovf, ras_unf;

  assign step   = bus.in_valid & ~bus.stall & ~bus.flush;
  assign seq_pc = pc_q + XLEN'(1);

  // Decode the opcode into a target address; all additions wrap silently.
  always_comb begin
    target_pc = seq_pc;
    is_link   = 1'b0;
    is_ret    = 1'b0;
    case (bus.opcode)
      OP_BEQ:  if (bus.compare[CMP_EQ]) target_pc = pc_q + bus.imm;
      OP_BNE:  if (bus.compare[CMP_NE]) target_pc = pc_q + bus.imm;
      OP_BGE:  if (bus.compare[CMP_GE]) target_pc = pc_q + bus.imm;
      OP_BLT:  if (bus.compare[CMP_LT]) target_pc = pc_q + bus.imm;
      OP_JAL: begin
        target_pc = pc_q + bus.imm;
        is_link   = 1'b1;
      end
      OP_JALR: begin
        target_pc = bus.ra + bus.imm;
        is_link   = 1'b1;
      end
      OP_RET: begin
        is_ret = 1'b1;
        if (ras_count != '0) target_pc = ras_top;
      end
      default: target_pc = seq_pc;
    endcase
  end

  // Next-state selection: flush beats stall beats step.
  always_comb begin
    pc_d       = pc_q;
    link_d     = link_q;
    link_we_d  = 1'b0;
    redirect_d = 1'b0;
    if (bus.flush) begin
      pc_d       = bus.flush_pc;
      redirect_d = 1'b1;
    end else if (step) begin
      pc_d       = target_pc;
      redirect_d = (target_pc != seq_pc);
      if (is_link) begin
        link_d    = seq_pc;
        link_we_d = 1'b1;
      end
    end
  end

  // Architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      link_q     <= '0;
      link_we_q  <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      link_q     <= link_d;
      link_we_q  <= link_we_d;
      redirect_q <= redirect_d;
    end
  end

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (step & is_link),
    .pop_i         (step & is_ret),
    .push_data_i   (seq_pc),
    .clear_flags_i (bus.clear_flags),
    .top_o         (ras_top),
    .count_o       (ras_count),
    .overflow_o    (ras_ovf),
    .underflow_o   (ras_unf)
  );

  assign bus.pc            = pc_q;
  assign bus.link          = link_q;
  assign bus.link_we       = link_we_q;
  assign bus.redirect      = redirect_q;
  assign bus.ras_count     = ras_count;
  assign bus.ras_overflow  = ras_ovf;
  assign bus.ras_underflow = ras_unf;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a table of single-cycle vectors followed by
// hand-written sequences for RAS overflow/underflow and mid-run reset.
module tb_pc_unit;
  localparam int XLEN = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

  pc_unit #(.XLEN(XLEN), .RAS_DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  typedef struct {
    logic        v, s, f;
    logic [15:0] fpc;
    logic [3:0]  op, cmp;
    logic [15:0] imm, ra;
    logic        clr;
    logic [15:0] e_pc, e_link;
    logic        e_we, e_red;
    logic [2:0]  e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic s, logic f, logic [15:0] fpc,
                              logic [3:0] op, logic [3:0] cmp, logic [15:0] imm,
                              logic [15:0] ra, logic clr, logic [15:0] e_pc,
                              logic [15:0] e_link, logic e_we, logic e_red,
                              logic [2:0] e_cnt, logic e_ovf, logic e_unf);
    vec_t t;
    t.v = v; t.s = s; t.f = f; t.fpc = fpc; t.op = op; t.cmp = cmp;
    t.imm = imm; t.ra = ra; t.clr = clr; t.e_pc = e_pc; t.e_link = e_link;
    t.e_we = e_we; t.e_red = e_red; t.e_cnt = e_cnt; t.e_ovf = e_ovf; t.e_unf = e_unf;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t t);
    bus.in_valid    = t.v;
    bus.stall       = t.s;
    bus.flush       = t.f;
    bus.flush_pc    = t.fpc;
    bus.opcode      = t.op;
    bus.compare     = t.cmp;
    bus.imm         = t.imm;
    bus.ra          = t.ra;
    bus.clear_flags = t.clr;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 16'h0, 4'h0, 4'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic op_step(input logic [3:0] op, input logic [15:0] imm);
    drive(mk(1, 0, 0, 16'h0, op, 4'h0, imm, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t t);
    check({tag, " pc"},       32'(bus.pc),            32'(t.e_pc));
    check({tag, " link"},     32'(bus.link),          32'(t.e_link));
    check({tag, " link_we"},  32'(bus.link_we),       32'(t.e_we));
    check({tag, " redirect"}, 32'(bus.redirect),      32'(t.e_red));
    check({tag, " count"},    32'(bus.ras_count),     32'(t.e_cnt));
    check({tag, " ovf"},      32'(bus.ras_overflow),  32'(t.e_ovf));
    check({tag, " unf"},      32'(bus.ras_underflow), 32'(t.e_unf));
  endtask

  logic [15:0] exp_q [$];

  initial begin
    // Directed vector table, one row per clock edge, starting from reset (pc=0).
    //            v  s  f  fpc       op       cmp      imm       ra        clr  pc        link      we red cnt ovf unf
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0001, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0003, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 4'b1011, 4'b0000, 16'h0040, 16'h0000, 0, 16'h0003, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0100, 4'b1111, 16'h0040, 16'h0000, 0, 16'h0004, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1111, 4'b1111, 16'h0040, 16'h0000, 0, 16'h0005, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1000, 4'b1111, 16'h0055, 16'h0000, 0, 16'h0006, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0010, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0010, 16'h0000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0101, 4'b1000, 16'hFFFC, 16'h0000, 0, 16'h000C, 16'h0000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h000D, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0010, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0010, 16'h0000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0101, 4'b0000, 16'hFFFC, 16'h0000, 0, 16'h0011, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0110, 4'b0100, 16'h0003, 16'h0000, 0, 16'h0014, 16'h0000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0110, 4'b1011, 16'h0003, 16'h0000, 0, 16'h0015, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0111, 4'b0010, 16'hFFFE, 16'h0000, 0, 16'h0013, 16'h0000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1001, 4'b0001, 16'h0005, 16'h0000, 0, 16'h0018, 16'h0000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1001, 4'b1110, 16'h0005, 16'h0000, 0, 16'h0019, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0101, 4'b1000, 16'h0001, 16'h0000, 0, 16'h001A, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1100, 4'b0000, 16'h0020, 16'h0100, 0, 16'h0120, 16'h001B, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0121, 16'h001B, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1101, 4'b0000, 16'h0000, 16'h0000, 0, 16'h001B, 16'h001B, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1101, 4'b0000, 16'h0000, 16'h0000, 0, 16'h001C, 16'h001B, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 1, 16'h001D, 16'h001B, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'hFFFF, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h001B, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1011, 4'b0000, 16'h0002, 16'h0000, 0, 16'h0001, 16'h0000, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1101, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 16'h0100, 4'b1011, 4'b0000, 16'h0040, 16'h0000, 0, 16'h0100, 16'h0000, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 4'b1011, 4'b0000, 16'h0040, 16'h0000, 0, 16'h0100, 16'h0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1011, 4'b0000, 16'h0040, 16'h0000, 0, 16'h0140, 16'h0101, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0140, 16'h0101, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0200, 4'b1011, 4'b0000, 16'h0040, 16'h0000, 0, 16'h0200, 16'h0101, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1101, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0101, 16'h0101, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b1101, 4'b0000, 16'h0000, 16'h0000, 1, 16'h0102, 16'h0101, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 1, 16'h0103, 16'h0101, 0, 0, 0, 0, 0));

    // ---------------- reset ----------------
    idle();
    #3;
    check_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0));
    cycle();
    cycle();
    rst_n = 1'b1;

    // ---------------- vector table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i]);
      cycle();
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // ---------------- RAS overflow / underflow ----------------
    drive(mk(1, 0, 1, 16'h0300, 4'h0, 4'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0));
    cycle();
    check("ovf_seq flush pc", 32'(bus.pc), 32'h0300);
    for (int i = 0; i < 5; i++) begin
      op_step(4'b1011, 16'h0010);
      check($sformatf("jal%0d pc", i), 32'(bus.pc), 32'h0310 + 32'(i) * 32'h10);
      check($sformatf("jal%0d count", i), 32'(bus.ras_count), (i < 4) ? 32'(i + 1) : 32'd4);
      check($sformatf("jal%0d ovf", i), 32'(bus.ras_overflow), (i == 4) ? 32'd1 : 32'd0);
    end
    exp_q = '{16'h0341, 16'h0331, 16'h0321, 16'h0311};
    for (int i = 0; i < 4; i++) begin
      op_step(4'b1101, 16'h0000);
      check($sformatf("ret%0d pc", i), 32'(bus.pc), 32'(exp_q.pop_front()));
      check($sformatf("ret%0d count", i), 32'(bus.ras_count), 32'(3 - i));
      check($sformatf("ret%0d unf", i), 32'(bus.ras_underflow), 32'd0);
    end
    op_step(4'b1101, 16'h0000);
    check("ret4 pc", 32'(bus.pc), 32'h0312);
    check("ret4 unf", 32'(bus.ras_underflow), 32'd1);
    check("ret4 ovf sticky", 32'(bus.ras_overflow), 32'd1);
    check("ret4 count", 32'(bus.ras_count), 32'd0);

    // ---------------- asynchronous reset mid-run ----------------
    for (int i = 0; i < 3; i++) op_step(4'b1011, 16'h0010);
    check("pre_rst count", 32'(bus.ras_count), 32'd3);
    check("pre_rst link_we", 32'(bus.link_we), 32'd1);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0));
    #1;
    rst_n = 1'b1;
    op_step(4'b1101, 16'h0000);
    check("post_rst ret pc", 32'(bus.pc), 32'h0001);
    check("post_rst ret unf", 32'(bus.ras_underflow), 32'd1);
    check("post_rst count", 32'(bus.ras_count), 32'd0);
    check("post_rst redirect", 32'(bus.redirect), 32'd0);

    idle();
    cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
